// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: bundle of the display-driver data/strobe inputs and
// the segment/digit/frame outputs. The master side drives din/load, and
// the slave side (the scanner) drives HEX/DIG_SEL/frame.
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] din;
  logic                    load;
  logic [6:0]              HEX;
  logic [NUM_DIGITS-1:0]   DIG_SEL;
  logic                    frame;

  modport master (
    output din,
    output load,
    input  HEX,
    input  DIG_SEL,
    input  frame
  );

  modport slave (
    input  din,
    input  load,
    output HEX,
    output DIG_SEL,
    output frame
  );
endinterface

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed hex display driver. A prescaler sets the
// dwell time per digit, a digit index walks 0..NUM_DIGITS-1, and the
// registered outputs present the active-low digit enable and the glyph of
// the selected nibble one clock after the index.
// Optional feature: define SEVEN_SEG_LZB_EN to enable leading-zero blanking
// (digit 0 is never blanked).
module seven_seg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input logic             clk,
  input logic             reset,
  seven_seg_scan_if.slave bus
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] disp_reg;
  logic [CW-1:0]           count_reg, count_next;
  logic [IW-1:0]           idx_reg, idx_next;
  logic                    wrap_reg, wrap_next;
  logic                    tick;
  logic [3:0]              nibble [NUM_DIGITS];
  logic [3:0]              sel_nibble;
  logic [6:0]              hex_next;
  logic [NUM_DIGITS-1:0]   dig_next;

  // Active-low {g,f,e,d,c,b,a} glyphs for the sixteen hex values.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h18;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Split the display register into per-digit nibbles.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
    assign nibble[gi] = disp_reg[4*gi +: 4];
  end

`ifdef SEVEN_SEG_LZB_EN
  // zero_from[k] is true when nibbles NUM_DIGITS-1 down to k are all zero;
  // that is exactly the condition for blanking digit k (k > 0).
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS:1]   zero_from;
  logic                  sel_blank;

  assign zero_from[NUM_DIGITS] = 1'b1;
  assign blank[0]              = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lzb
    assign zero_from[gi] = zero_from[gi+1] & (nibble[gi] == 4'h0);
    assign blank[gi]     = zero_from[gi];
  end
`endif

  // Select the nibble (and blanking flag) of the digit currently scanned.
  always_comb begin
    sel_nibble = 4'h0;
`ifdef SEVEN_SEG_LZB_EN
    sel_blank  = 1'b0;
`endif
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_reg == IW'(k)) begin
        sel_nibble = nibble[k];
`ifdef SEVEN_SEG_LZB_EN
        sel_blank  = blank[k];
`endif
      end
    end
  end

  // Next-state of prescaler, digit index and the wrap marker that becomes frame.
  always_comb begin
    tick       = (count_reg == LAST_COUNT);
    count_next = tick ? '0 : count_reg + 1'b1;
    idx_next   = idx_reg;
    if (tick) begin
      idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
    end
    wrap_next  = tick && (idx_reg == LAST_IDX);
  end

  // Output values to be registered: digit enable and glyph follow idx by one clock.
  always_comb begin
    dig_next = ~(NUM_DIGITS'(1) << idx_reg);
    hex_next = glyph(sel_nibble);
`ifdef SEVEN_SEG_LZB_EN
    if (sel_blank) begin
      hex_next = 7'h7F;
    end
`endif
  end

  // Scan timing state: prescaler, digit index, wrap marker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      idx_reg   <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      idx_reg   <= idx_next;
      wrap_reg  <= wrap_next;
    end
  end

  // Display register: captures din on load, otherwise holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_reg <= '0;
    end else if (bus.load) begin
      disp_reg <= bus.din;
    end
  end

  // Registered outputs; frame lines up with DIG_SEL returning to digit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.HEX     <= 7'h7F;
      bus.DIG_SEL <= '1;
      bus.frame   <= 1'b0;
    end else begin
      bus.HEX     <= hex_next;
      bus.DIG_SEL <= dig_next;
      bus.frame   <= wrap_reg;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: scoreboard bench for seven_seg_scan (NUM_DIGITS=4,
// PRESCALE=4). The stimulus side pushes the expected output of every clock
// edge, computed from edge number and display contents; the monitor pops
// and compares on each falling edge.
module tb_seven_seg_scan;
  localparam int N     = 4;
  localparam int P     = 4;
  localparam int FRAME = N * P;
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seven_seg_scan_if #(.NUM_DIGITS(N)) bus ();
  seven_seg_scan #(.NUM_DIGITS(N), .PRESCALE(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0]  edge_no;
    logic [6:0]   hex;
    logic [N-1:0] dig;
    logic         frame;
  } exp_t;

  exp_t        sb_q [$];
  int          errors = 0;
  int          checks = 0;
  int unsigned e_cnt = 0;
  logic [15:0] model_disp = 16'h0;
  logic [6:0]  seen [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: after the e-th edge since reset release, digit ((e-1)/P) mod N
  // is lit with the glyph of the display contents held before that edge;
  // frame is high once per N*P edges, starting at edge N*P+1.
  function automatic exp_t model_expect(input int unsigned e, input logic [15:0] disp);
    exp_t        r;
    int unsigned slot;
    logic [15:0] upper;
    slot      = ((e - 1) / P) % N;
    upper     = disp >> (4 * slot);
    r.edge_no = e;
    r.dig     = '1;
    r.dig[slot] = 1'b0;
    r.hex     = GLYPH[upper[3:0]];
`ifdef SEVEN_SEG_LZB_EN
    if (slot != 0 && upper == 16'h0) r.hex = 7'h7F;
`endif
    r.frame   = (e > 1) && ((e - 1) % FRAME == 0);
    return r;
  endfunction

  // Set up the inputs for the next edge and record what that edge must produce.
  task automatic issue(input logic ld, input logic [15:0] d);
    e_cnt++;
    sb_q.push_back(model_expect(e_cnt, model_disp));
    bus.load = ld;
    bus.din  = d;
    if (ld) model_disp = d;
  endtask

  task automatic step(input logic ld, input logic [15:0] d);
    @(negedge clk);
    #1;
    issue(ld, d);
  endtask

  task automatic run_idle(input int n);
    repeat (n) step(1'b0, 16'($urandom));
  endtask

  task automatic check_seen(input string tag, input logic [7*N-1:0] req);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_dig%0d", tag, k), 32'(seen[k]), 32'(req[7*k +: 7]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hex"}, 32'(bus.HEX), 32'h7F);
    chk({tag, "_dig"}, 32'(bus.DIG_SEL), 32'hF);
    chk({tag, "_frame"}, 32'(bus.frame), 32'h0);
  endtask

  // Monitor: one comparison set per clock edge, plus the last glyph seen per digit.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!reset && sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk($sformatf("hex@%0d", x.edge_no), 32'(bus.HEX), 32'(x.hex));
        chk($sformatf("dig@%0d", x.edge_no), 32'(bus.DIG_SEL), 32'(x.dig));
        chk($sformatf("frame@%0d", x.edge_no), 32'(bus.frame), 32'(x.frame));
        $display("edge %0d: DIG_SEL=%h HEX=%h frame=%0b", x.edge_no, bus.DIG_SEL, bus.HEX, bus.frame);
        for (int k = 0; k < N; k++) begin
          if (bus.DIG_SEL == ~(N'(1) << k)) seen[k] = bus.HEX;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7*N-1:0] exp_zero;
`ifdef SEVEN_SEG_LZB_EN
    exp_zero = {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
    exp_zero = {7'h40, 7'h40, 7'h40, 7'h40};
`endif
    bus.load = 1'b0;
    bus.din  = '0;

    // Held in reset: blank, all digits off, no frame.
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset_hold");

    // Release with din=0 and watch a bit more than one frame.
    @(negedge clk);
    #1;
    reset = 1'b0;
    issue(1'b0, 16'h0);
    run_idle(FRAME + 4);

    // Load 1A2F and observe a full frame.
    step(1'b1, 16'h1A2F);
    run_idle(FRAME + 4);
    check_seen("load1A2F", {7'h79, 7'h08, 7'h24, 7'h0E});

    // Load 00F0: interior zeros only blanked when leading.
    step(1'b1, 16'h00F0);
    run_idle(FRAME + 4);
`ifdef SEVEN_SEG_LZB_EN
    check_seen("load00F0", {7'h7F, 7'h7F, 7'h0E, 7'h40});
`else
    check_seen("load00F0", {7'h40, 7'h40, 7'h0E, 7'h40});
`endif

    // All zero.
    step(1'b1, 16'h0000);
    run_idle(FRAME + 4);
    check_seen("load0000", exp_zero);

    // Load exactly on the tick edge into digit 2.
    while (((e_cnt + 1) % FRAME) != 8) step(1'b0, 16'($urandom));
    step(1'b1, 16'h0800);
    run_idle(FRAME + 4);
`ifdef SEVEN_SEG_LZB_EN
    check_seen("load0800", {7'h7F, 7'h00, 7'h40, 7'h40});
`else
    check_seen("load0800", {7'h40, 7'h00, 7'h40, 7'h40});
`endif

    // Random loads and data.
    repeat (600) step(($urandom_range(0, 7) == 0), 16'($urandom));

    // Non-zero contents, then reset asserted mid-frame while digit 2 is scanned.
    step(1'b1, 16'hBEEF);
    while ((e_cnt % FRAME) != 10) step(1'b0, 16'($urandom));
    @(negedge clk);
    #1;
    reset    = 1'b1;
    bus.load = 1'b1;
    bus.din  = 16'h5555;
    #1;
    check_reset_outputs("reset_mid");
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset_mid_hold");

    // Restart: display cleared, scan from digit 0.
    e_cnt      = 0;
    model_disp = 16'h0;
    reset      = 1'b0;
    issue(1'b0, 16'h0);
    run_idle(FRAME + 4);
    check_seen("restart", exp_zero);

    // Let the monitor drain the last expectation.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain_left", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
